// File: rtl/miiulator_top.sv
`timescale 1ns/1ps
// miiulator_top: MII receive front end that strips preamble/SFD, packs nibbles
// into bytes, queues them in a byte FIFO and dumps them raw over an 8N1 UART.
// Optional build macro: MII_BITREV_EN bit-reverses the synchronized RXD nibble
// for boards that wire RXD[3:0] in reverse order.
//
// Internal handshake: the receive FSM raises `push` for one cycle with
// `push_data`; the FIFO accepts it when not full, or when full but popped in
// the same cycle. The UART raises `pop` only when the FIFO is non-empty and the
// transmitter can load a byte; the popped byte is mem[rd_ptr] in that cycle.
module miiulator_top #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 64
) (
   input  logic       clk,
   input  logic       SW0,
   input  logic       uart_rx_serial,
   output logic       uart_tx_serial,
   output logic [7:0] LED,
   input  logic       mii0_en,
   input  logic       mii0_clk,
   input  logic [3:0] mii0_d,
   output logic [1:0] dbg_rx_state
);

   localparam int AW     = $clog2(FIFO_DEPTH);
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);

   typedef enum logic [1:0] {RX_IDLE, RX_PRE, RX_LO, RX_HI} rx_state_t;

   logic unused_rx;
   assign unused_rx = uart_rx_serial;

   // ---------------- input synchronizers ----------------
   logic [1:0] mclk_sync;
   logic [1:0] en_sync;
   logic [3:0] d_s1, d_s2;
   logic       mclk_prev;

   // Two-flop synchronizers plus one delay stage for RX_CLK edge detection
   always_ff @(posedge clk or negedge SW0) begin
      if (!SW0) begin
         mclk_sync <= 2'b00;
         en_sync   <= 2'b00;
         d_s1      <= 4'h0;
         d_s2      <= 4'h0;
         mclk_prev <= 1'b0;
      end else begin
         mclk_sync <= {mclk_sync[0], mii0_clk};
         en_sync   <= {en_sync[0], mii0_en};
         d_s1      <= mii0_d;
         d_s2      <= d_s1;
         mclk_prev <= mclk_sync[1];
      end
   end

   logic       strobe;
   logic       en_s;
   logic [3:0] nib;
   assign strobe = mclk_sync[1] & ~mclk_prev;
   assign en_s   = en_sync[1];
`ifdef MII_BITREV_EN
   assign nib = {d_s2[0], d_s2[1], d_s2[2], d_s2[3]};
`else
   assign nib = d_s2;
`endif

   // ---------------- receive FSM ----------------
   rx_state_t  rx_state, rx_next;
   logic       lo_we, push, frame_end;
   logic [3:0] lo_nib;
   logic [7:0] push_data;

   assign push_data    = {nib, lo_nib};
   assign dbg_rx_state = rx_state;

   // Receive state register and low-nibble holding register
   always_ff @(posedge clk or negedge SW0) begin
      if (!SW0) begin
         rx_state <= RX_IDLE;
         lo_nib   <= 4'h0;
      end else begin
         rx_state <= rx_next;
         if (lo_we) lo_nib <= nib;
      end
   end

   // Next-state and per-strobe actions; nothing moves between strobes
   always_comb begin
      rx_next   = rx_state;
      lo_we     = 1'b0;
      push      = 1'b0;
      frame_end = 1'b0;
      if (strobe) begin
         case (rx_state)
            RX_IDLE: if (en_s && nib == 4'h5) rx_next = RX_PRE;
            RX_PRE: begin
               if (!en_s)            rx_next = RX_IDLE;
               else if (nib == 4'h5) rx_next = RX_PRE;
               else if (nib == 4'hD) rx_next = RX_LO;
               else                  rx_next = RX_IDLE;
            end
            RX_LO: begin
               if (en_s) begin
                  lo_we   = 1'b1;
                  rx_next = RX_HI;
               end else begin
                  frame_end = 1'b1;
                  rx_next   = RX_IDLE;
               end
            end
            default: begin
               if (en_s) begin
                  push    = 1'b1;
                  rx_next = RX_LO;
               end else begin
                  frame_end = 1'b1;
                  rx_next   = RX_IDLE;
               end
            end
         endcase
      end
   end

   // ---------------- byte FIFO ----------------
   logic [7:0]  mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic        full, empty, pop, push_ok;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign push_ok = push && (!full || pop);

   // FIFO storage; no reset needed, occupancy is tracked by the pointers
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   logic [6:0] frame_cnt;
   logic       overflow;

   // Pointers, completed-frame counter and sticky overflow flag
   always_ff @(posedge clk or negedge SW0) begin
      if (!SW0) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         frame_cnt <= 7'd0;
         overflow  <= 1'b0;
      end else begin
         if (push_ok)          wr_ptr    <= wr_ptr + 1'b1;
         if (pop)              rd_ptr    <= rd_ptr + 1'b1;
         if (frame_end)        frame_cnt <= frame_cnt + 7'd1;
         if (push && !push_ok) overflow  <= 1'b1;
      end
   end

   assign LED = {overflow, frame_cnt};

   // ---------------- UART transmitter ----------------
   logic [9:0]        tx_shift;
   logic [3:0]        bit_cnt;
   logic [BAUD_W-1:0] baud_cnt;
   logic              tx_busy;
   logic              bit_done;

   assign bit_done = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
   // Loading during the final stop-bit cycle keeps back-to-back bytes gapless
   assign pop      = !empty && (!tx_busy || (bit_done && bit_cnt == 4'd9));

   // Frame shifter: {stop, data[7:0], start} shifted out LSB first
   always_ff @(posedge clk or negedge SW0) begin
      if (!SW0) begin
         tx_shift <= 10'h3FF;
         bit_cnt  <= 4'd0;
         baud_cnt <= '0;
         tx_busy  <= 1'b0;
      end else if (pop) begin
         tx_shift <= {1'b1, mem[rd_ptr[AW-1:0]], 1'b0};
         bit_cnt  <= 4'd0;
         baud_cnt <= '0;
         tx_busy  <= 1'b1;
      end else if (tx_busy) begin
         if (bit_done) begin
            baud_cnt <= '0;
            if (bit_cnt == 4'd9) begin
               tx_busy <= 1'b0;
            end else begin
               bit_cnt  <= bit_cnt + 4'd1;
               tx_shift <= {1'b1, tx_shift[9:1]};
            end
         end else begin
            baud_cnt <= baud_cnt + 1'b1;
         end
      end
   end

   assign uart_tx_serial = tx_busy ? tx_shift[0] : 1'b1;

endmodule

// File: tb/tb_miiulator_top.sv
`timescale 1ns/1ps
// Bench for miiulator_top: directed MII frames in, UART bytes decoded out.
module tb_miiulator_top;

   localparam int C = 8;

   logic       clk = 1'b0;
   logic       SW0 = 1'b0;
   logic       uart_rx_serial = 1'b1;
   logic       uart_tx_serial;
   logic [7:0] LED;
   logic       mii0_en = 1'b0;
   logic       mii0_clk = 1'b0;
   logic [3:0] mii0_d = 4'h0;
   logic [1:0] dbg_rx_state;

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;

   logic [7:0] exp_q[$];
   logic [7:0] rx_q[$];
   logic [7:0] frame_q[$];
   int         start_q[$];
   logic [7:0] mon_b;

   miiulator_top #(.CLKS_PER_BIT(C), .FIFO_DEPTH(64)) dut (
      .clk(clk),
      .SW0(SW0),
      .uart_rx_serial(uart_rx_serial),
      .uart_tx_serial(uart_tx_serial),
      .LED(LED),
      .mii0_en(mii0_en),
      .mii0_clk(mii0_clk),
      .mii0_d(mii0_d),
      .dbg_rx_state(dbg_rx_state)
   );

   // clock / reset block: 50 MHz system clock
   always #10 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   // UART decoder: mid-bit sampling, framing checked on every byte
   initial begin
      forever begin
         @(negedge clk);
         if (uart_tx_serial === 1'b0) begin
            start_q.push_back(cyc);
            repeat (C / 2) @(negedge clk);
            checks++;
            if (uart_tx_serial !== 1'b0) begin
               fails++;
               $display("FAIL uart_start_bit: got %b want 0", uart_tx_serial);
            end
            for (int i = 0; i < 8; i++) begin
               repeat (C) @(negedge clk);
               mon_b[i] = uart_tx_serial;
            end
            repeat (C) @(negedge clk);
            checks++;
            if (uart_tx_serial !== 1'b1) begin
               fails++;
               $display("FAIL uart_stop_bit: got %b want 1", uart_tx_serial);
            end
            rx_q.push_back(mon_b);
         end
      end
   end

   // driver: one MII nibble, 25 MHz RX_CLK, data changes while RX_CLK is low
   task automatic mii_nibble(input logic en, input logic [3:0] d);
      mii0_en = en;
`ifdef MII_BITREV_EN
      mii0_d = {d[0], d[1], d[2], d[3]};
`else
      mii0_d = d;
`endif
      mii0_clk = 1'b0;
      #20;
      mii0_clk = 1'b1;
      #20;
   endtask

   // driver: preamble + SFD + frame_q bytes (low nibble first), optional odd tail
   task automatic send_frame(input bit odd, input logic [3:0] tail);
      for (int i = 0; i < 15; i++) mii_nibble(1'b1, 4'h5);
      mii_nibble(1'b1, 4'hD);
      foreach (frame_q[i]) begin
         mii_nibble(1'b1, frame_q[i][3:0]);
         mii_nibble(1'b1, frame_q[i][7:4]);
      end
      if (odd) mii_nibble(1'b1, tail);
      for (int i = 0; i < 4; i++) mii_nibble(1'b0, 4'h0);
   endtask

   task automatic wait_rx(input int n, input int budget);
      int k;
      k = 0;
      while (rx_q.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      repeat (30 * C) @(negedge clk);
   endtask

   task automatic test_reset();
      SW0 = 1'b0;
      #25;
      SW0 = 1'b1;
      @(negedge clk);
      checks++;
      if (LED !== 8'h00) begin
         fails++;
         $display("FAIL reset_led: got %h want 00", LED);
      end
      checks++;
      if (uart_tx_serial !== 1'b1) begin
         fails++;
         $display("FAIL reset_tx_idle: got %b want 1", uart_tx_serial);
      end
      checks++;
      if (dbg_rx_state !== 2'd0) begin
         fails++;
         $display("FAIL reset_rx_state: got %0d want 0", dbg_rx_state);
      end
      repeat (200) @(negedge clk);
      checks++;
      if (rx_q.size() != 0) begin
         fails++;
         $display("FAIL reset_no_uart: got %0d bytes want 0", rx_q.size());
      end
   endtask

   task automatic test_bad_preamble();
      logic [7:0] data [4];
      data[0] = 8'h12; data[1] = 8'h34; data[2] = 8'h67; data[3] = 8'h89;
      rx_q.delete();
      mii_nibble(1'b1, 4'h5);
      mii_nibble(1'b1, 4'h5);
      mii_nibble(1'b1, 4'h3);
      mii_nibble(1'b1, 4'hD);
      for (int i = 0; i < 4; i++) begin
         mii_nibble(1'b1, data[i][3:0]);
         mii_nibble(1'b1, data[i][7:4]);
      end
      for (int i = 0; i < 4; i++) mii_nibble(1'b0, 4'h0);
      repeat (300) @(negedge clk);
      checks++;
      if (rx_q.size() != 0) begin
         fails++;
         $display("FAIL bad_pre_bytes: got %0d want 0", rx_q.size());
      end
      checks++;
      if (LED !== 8'h00) begin
         fails++;
         $display("FAIL bad_pre_led: got %h want 00", LED);
      end
   endtask

   task automatic test_standard_frame();
      frame_q = '{8'h54, 8'hff, 8'h01, 8'h21, 8'h23, 8'h24,
                  8'h12, 8'h34, 8'h56, 8'h78, 8'h9a, 8'hbc, 8'h12, 8'h34};
      for (int i = 0; i < 32; i++) frame_q.push_back(8'(i * 7 + 3));
      frame_q.push_back(8'hde); frame_q.push_back(8'had);
      frame_q.push_back(8'hbe); frame_q.push_back(8'hef);
      exp_q = frame_q;
      rx_q.delete();
      start_q.delete();
      send_frame(1'b0, 4'h0);
      checks++;
      if (LED !== 8'h01) begin
         fails++;
         $display("FAIL std_led: got %h want 01", LED);
      end
      wait_rx(50, 6000);
      checks++;
      if (rx_q.size() != 50) begin
         fails++;
         $display("FAIL std_count: got %0d want 50", rx_q.size());
      end
      checks++;
      if (rx_q.size() == 0 || rx_q[0] !== 8'h54) begin
         fails++;
         $display("FAIL std_first_byte: got %h want 54", rx_q.size() ? rx_q[0] : 8'hxx);
      end
      for (int i = 0; i < 50 && i < rx_q.size(); i++) begin
         checks++;
         if (rx_q[i] !== exp_q[i]) begin
            fails++;
            $display("FAIL std_byte[%0d]: got %h want %h", i, rx_q[i], exp_q[i]);
         end
      end
      for (int i = 1; i < start_q.size(); i++) begin
         checks++;
         if (start_q[i] - start_q[i-1] != 10 * C) begin
            fails++;
            $display("FAIL std_b2b_gap[%0d]: got %0d want %0d", i, start_q[i] - start_q[i-1], 10 * C);
         end
      end
   endtask

   task automatic test_odd_nibble();
      frame_q = '{8'hA1, 8'hB2, 8'hC3};
      exp_q = frame_q;
      rx_q.delete();
      send_frame(1'b1, 4'h7);
      checks++;
      if (LED !== 8'h02) begin
         fails++;
         $display("FAIL odd_led: got %h want 02", LED);
      end
      wait_rx(3, 2000);
      checks++;
      if (rx_q.size() != 3) begin
         fails++;
         $display("FAIL odd_count: got %0d want 3", rx_q.size());
      end
      for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
         checks++;
         if (rx_q[i] !== exp_q[i]) begin
            fails++;
            $display("FAIL odd_byte[%0d]: got %h want %h", i, rx_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_overflow();
      frame_q.delete();
      for (int i = 0; i < 80; i++) frame_q.push_back(8'(i));
      rx_q.delete();
      send_frame(1'b0, 4'h0);
      checks++;
      if (LED !== 8'h83) begin
         fails++;
         $display("FAIL ovf_led: got %h want 83", LED);
      end
      repeat (7000) @(negedge clk);
      checks++;
      if (rx_q.size() < 64 || rx_q.size() >= 80) begin
         fails++;
         $display("FAIL ovf_count: got %0d want 64..79", rx_q.size());
      end
      for (int i = 0; i < rx_q.size(); i++) begin
         checks++;
         if (i < 64) begin
            if (rx_q[i] !== 8'(i)) begin
               fails++;
               $display("FAIL ovf_prefix[%0d]: got %h want %h", i, rx_q[i], 8'(i));
            end
         end else if (rx_q[i] <= rx_q[i-1] || rx_q[i] >= 8'd80) begin
            fails++;
            $display("FAIL ovf_order[%0d]: got %h want >%h and <50", i, rx_q[i], rx_q[i-1]);
         end
      end
   endtask

   initial begin
      #3;
      test_reset();
      test_bad_preamble();
      test_standard_frame();
      test_odd_nibble();
      test_overflow();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
